conv3_window_ctrl: RTL and testbench

- Streams one feature-map plane (one pixel per handshake) into the layer-3 convolution datapath (conv3_calc).
- Uses two line buffers to build 3x3 windows and issues each window with a one-cycle valid strobe.
- Counts the datapath's output strobes and signals frame completion, so the top level can sequence successive planes.

---
 rtl/conv3_pkg.sv | 21 ++
 rtl/conv3_line_buffer.sv | 30 +++
 rtl/conv3_window_ctrl.sv | 131 +++++++++++++
 tb/tb_conv3_window_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3_pkg.sv
// Shared constants, types and helpers for the layer-3 convolution window controller.
package conv3_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t [2:0][2:0]   window_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of valid 3x3 windows in an unpadded plane.
  function automatic int unsigned total_windows(input int unsigned img_w, input int unsigned img_h);
    return (img_h - 2) * (img_w - 2);
  endfunction

endpackage

// File: rtl/conv3_line_buffer.sv
// Circular delay line of DEPTH words, advanced once per enable; read-before-write at the shared pointer.
module conv3_line_buffer #(
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;

  assign rd_data_c = mem_q[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[ptr_q] <= wr_data_i;
      ptr_q        <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/conv3_window_ctrl.sv
// Streams a plane into 3x3 windows for conv3_calc and counts its output strobes to detect frame end.
module conv3_window_ctrl #(
  parameter int unsigned IMG_W  = 12,
  parameter int unsigned IMG_H  = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [DATA_W-1:0]                            pix_in,
  input  logic                                         pix_valid,
  output logic                                         pix_ready,
  output logic [2:0][2:0][DATA_W-1:0]                  win_out,
  output logic                                         win_valid,
  input  logic                                         conv_valid,
  output logic                                         busy,
  output logic                                         frame_done,
  output logic [$clog2((IMG_H-2)*(IMG_W-2)+1)-1:0]     out_cnt
);

  import conv3_pkg::*;

  localparam int unsigned TOTAL = total_windows(IMG_W, IMG_H);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef logic [2:0][2:0][DATA_W-1:0] win_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  win_t              win_q, win_d;
  logic              win_valid_q, win_valid_d;
  logic              pix_ready_q, busy_q, frame_done_q;
  logic              accept_c, last_pix_c, cnt_inc_c;
  logic [DATA_W-1:0] lb1_rd_c, lb2_rd_c;

  assign accept_c   = pix_valid && pix_ready_q;
  assign last_pix_c = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign cnt_inc_c  = conv_valid && ((state_q == STREAM) || (state_q == DRAIN));

  // The window's right-column registers supply the extra tap, so each row delay is IMG_W-1 deep.
  conv3_line_buffer #(.DEPTH(IMG_W - 1), .DATA_W(DATA_W)) u_lb1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (accept_c),
    .wr_data_i (win_q[2][2]),
    .rd_data_c (lb1_rd_c)
  );

  conv3_line_buffer #(.DEPTH(IMG_W - 1), .DATA_W(DATA_W)) u_lb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (accept_c),
    .wr_data_i (win_q[1][2]),
    .rd_data_c (lb2_rd_c)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    cnt_d       = cnt_inc_c ? cnt_q + CNT_W'(1) : cnt_q;

    if (accept_c) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb2_rd_c;
      win_d[1][2] = lb1_rd_c;
      win_d[2][2] = pix_in;
      win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        row_d   = '0;
        col_d   = '0;
        cnt_d   = '0;
      end
      STREAM:  if (accept_c && last_pix_c) state_d = DRAIN;
      DRAIN:   if (cnt_d == CNT_W'(TOTAL)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      pix_ready_q  <= (state_d == STREAM);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign out_cnt    = cnt_q;

endmodule

// File: tb/tb_conv3_window_ctrl.sv
// Bench for conv3_window_ctrl: 4x4 and 12x12 instances, scoreboarded windows, 5-cycle datapath model.
module tb_conv3_window_ctrl;
  import conv3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start12;
  logic [31:0] pix_in;
  logic        pix_valid;
  logic        conv_valid;

  window_t     win4, win12;
  logic        ready4, ready12, wv4, wv12, busy4, busy12, done4, done12;
  logic [2:0]  cnt4;
  logic [6:0]  cnt12;

  logic        sel;
  window_t     act_win;
  logic        act_ready, act_wv, act_busy, act_done;
  logic [6:0]  act_cnt;

  always #5 clk = ~clk;

  conv3_window_ctrl #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(ready4), .win_out(win4), .win_valid(wv4), .conv_valid(conv_valid),
    .busy(busy4), .frame_done(done4), .out_cnt(cnt4));

  conv3_window_ctrl #(.IMG_W(12), .IMG_H(12), .DATA_W(32)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(ready12), .win_out(win12), .win_valid(wv12), .conv_valid(conv_valid),
    .busy(busy12), .frame_done(done12), .out_cnt(cnt12));

  assign act_win   = sel ? win12   : win4;
  assign act_ready = sel ? ready12 : ready4;
  assign act_wv    = sel ? wv12    : wv4;
  assign act_busy  = sel ? busy12  : busy4;
  assign act_done  = sel ? done12  : done4;
  assign act_cnt   = sel ? cnt12   : {4'b0000, cnt4};

  typedef struct {
    window_t win;
    int      cyc;
  } exp_t;

  typedef struct {
    bit s;
    int base;
    bit gaps;
    bit poke;
    int exp_total;
  } frame_vec_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_seen = 0;
  int         win_seen = 0;
  int         cur_total = 0;
  logic [4:0] dl = '0;

  function automatic logic [31:0] pixval(input int b, input int w, input int r, input int c);
    return 32'(b + r * w + c);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start12 = v;
    else     start4  = v;
  endtask

  // One clock: sample outputs 1ns after the edge, score windows, advance the datapath model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (act_done) begin
      done_seen++;
      chk("done_latency", longint'(conv_valid), 1);
      chk("done_out_cnt", longint'(act_cnt), longint'(cur_total));
    end
    if (act_wv) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL win_unexpected cyc=%0d actual=%h required=none", cyc, act_win);
      end else begin
        e = exp_q.pop_front();
        win_seen++;
        chk("win_cycle", longint'(cyc), longint'(e.cyc));
        n_vec++;
        if (act_win !== e.win) begin
          n_err++;
          $display("FAIL win_data k=%0d actual=%h required=%h", win_seen - 1, act_win, e.win);
        end
      end
    end
    dl         = {dl[3:0], act_wv};
    conv_valid = dl[4];
  endtask

  task automatic run_frame(input bit s, input int base, input bit gaps, input bit poke,
                           input bit settle, input int exp_total);
    int   w, r, c, n, guard;
    bit   pv, acc;
    exp_t e;
    sel       = s;
    w         = s ? 12 : 4;
    cur_total = exp_total;
    done_seen = 0;
    win_seen  = 0;
    r = 0; c = 0; n = 0; guard = 0;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    while (r < w && guard < 3000) begin
      pv        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = pv;
      pix_in    = pv ? pixval(base, w, r, c) : 32'hDEAD_BEEF;
      set_start(poke && n == 5);
      acc = pv && act_ready;
      if (acc && r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i][j] = pixval(base, w, r - 2 + i, c - 2 + j);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      tick();
      if (acc) begin
        n++;
        c++;
        if (c == w) begin
          c = 0;
          r++;
        end
      end
      guard++;
    end
    pix_valid = 1'b0;
    set_start(1'b0);
    if (guard >= 3000) chk("stream_timeout", longint'(n), longint'(w * w));
    guard = 0;
    while (done_seen == 0 && guard < 200) begin
      set_start(poke && guard == 0);
      tick();
      guard++;
    end
    set_start(1'b0);
    chk("frame_done_seen", longint'(done_seen), 1);
    chk("windows_seen", longint'(win_seen), longint'(exp_total));
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    if (settle) begin
      repeat (10) tick();
      chk("single_frame_done", longint'(done_seen), 1);
      chk("idle_after_done", longint'(act_busy), 0);
      chk("out_cnt_hold", longint'(act_cnt), longint'(exp_total));
    end else begin
      // start in the DONE cycle must not launch a frame
      set_start(1'b1);
      tick();
      set_start(1'b0);
      chk("start_in_done_ignored", longint'(act_busy), 0);
    end
  endtask

  frame_vec_t tbl[4];

  initial begin
    int n;
    tbl[0] = '{s: 1'b0, base: 0,   gaps: 1'b0, poke: 1'b0, exp_total: 4};
    tbl[1] = '{s: 1'b0, base: 0,   gaps: 1'b1, poke: 1'b0, exp_total: 4};
    tbl[2] = '{s: 1'b1, base: 0,   gaps: 1'b0, poke: 1'b0, exp_total: 100};
    tbl[3] = '{s: 1'b1, base: 200, gaps: 1'b0, poke: 1'b1, exp_total: 100};

    rst_n = 1'b0; start4 = 1'b0; start12 = 1'b0; sel = 1'b0;
    pix_in = '0; pix_valid = 1'b0; conv_valid = 1'b0;
    tick();
    tick();
    chk("reset_ready", longint'(act_ready), 0);
    chk("reset_win_valid", longint'(act_wv), 0);
    chk("reset_busy", longint'(act_busy), 0);
    chk("reset_done", longint'(act_done), 0);
    chk("reset_out_cnt", longint'(act_cnt), 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++)
      run_frame(tbl[k].s, tbl[k].base, tbl[k].gaps, tbl[k].poke, 1'b1, tbl[k].exp_total);

    // Reset after 7 accepted pixels, then late datapath strobes while idle.
    sel = 1'b0;
    cur_total = 4;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    n = 0;
    while (n < 7) begin
      pix_valid = 1'b1;
      pix_in    = pixval(0, 4, n / 4, n % 4);
      tick();
      n++;
    end
    pix_valid = 1'b0;
    chk("pre_reset_busy", longint'(act_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", longint'(act_ready), 0);
    chk("async_rst_busy", longint'(act_busy), 0);
    chk("async_rst_win_valid", longint'(act_wv), 0);
    chk("async_rst_out_cnt", longint'(act_cnt), 0);
    chk("async_rst_win_zero", longint'(act_win == '0), 1);
    exp_q.delete();
    tick();
    rst_n      = 1'b1;
    dl         = 5'b11111;
    conv_valid = 1'b1;
    repeat (7) tick();
    chk("late_strobes_ignored", longint'(act_cnt), 0);
    chk("late_strobes_idle", longint'(act_busy), 0);
    run_frame(1'b0, 500, 1'b0, 1'b0, 1'b1, 4);

    // Back-to-back frames, second one started on the first IDLE cycle.
    run_frame(1'b0, 1000, 1'b0, 1'b0, 1'b0, 4);
    run_frame(1'b0, 2000, 1'b1, 1'b0, 1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
